// File: rtl/door_motor_arbiter_pkg.sv
// Shared types and default sizing for the door motor arbiter.
// The state enum is used by the top and visible to anything that inspects the FSM.
package door_ctrl_pkg;

  localparam int DEF_NUM_DOORS   = 4;
  localparam int DEF_TIMEOUT_CYC = 1000;
  localparam int DEF_DEAD_CYC    = 8;
  localparam int TMR_W           = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE_UP = 2'd1,
    MOVE_DN = 2'd2,
    DEAD    = 2'd3
  } state_e;

endpackage

// File: rtl/door_motor_arbiter_if.sv
// Door request/sensor bundle and shared-motor outputs.
// The slave side is the arbiter; the master side is whatever drives doors and sensors.
interface door_motor_arbiter_if
  import door_ctrl_pkg::*;
#(
  parameter int NUM_DOORS = DEF_NUM_DOORS
);
  localparam int SEL_W = $clog2(NUM_DOORS);

  logic [NUM_DOORS-1:0] Req_Up;
  logic [NUM_DOORS-1:0] Req_Dn;
  logic [NUM_DOORS-1:0] Up_Max;
  logic [NUM_DOORS-1:0] Dn_Max;
  logic                 Fault_Clr;
  logic                 Up_M;
  logic                 Dn_M;
  logic [SEL_W-1:0]     Sel;
  logic                 Busy;
  logic [NUM_DOORS-1:0] Fault;

  modport master (
    output Req_Up, Req_Dn, Up_Max, Dn_Max, Fault_Clr,
    input  Up_M, Dn_M, Sel, Busy, Fault
  );

  modport slave (
    input  Req_Up, Req_Dn, Up_Max, Dn_Max, Fault_Clr,
    output Up_M, Dn_M, Sel, Busy, Fault
  );

endinterface

// File: rtl/door_motor_arbiter_rr.sv
// Combinational round-robin pick: first request found after ptr, wrapping at N-1.
// Produces a one-hot grant and a valid flag; no state of its own.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic                 vld
);
  localparam int PW = $clog2(N);

  logic [PW-1:0] idx;

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = '0;
    // Offset N lands back on ptr itself, so the last-granted door is checked last.
    for (int off = 1; off <= N; off++) begin
      idx = PW'((int'(ptr) + off) % N);
      if (!vld && req[idx]) begin
        gnt[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/door_motor_arbiter.sv
// Shares one up/down motor driver between NUM_DOORS doors with round-robin grants,
// a per-move timeout, sensor-conflict faults and a fixed motor-off dead time.
module door_motor_arbiter
  import door_ctrl_pkg::*;
#(
  parameter int NUM_DOORS   = DEF_NUM_DOORS,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int DEAD_CYC    = DEF_DEAD_CYC
) (
  input logic                CLK,
  input logic                RST,
  door_motor_arbiter_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_DOORS);

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [NUM_DOORS-1:0] fault_q, fault_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [TMR_W-1:0]     dead_q, dead_d;
  logic                 up_m_q, dn_m_q, busy_q;

  logic [NUM_DOORS-1:0] elig_up, elig_dn, elig;
  logic [NUM_DOORS-1:0] gnt;
  logic                 gnt_vld;
  logic [SEL_W-1:0]     gnt_idx;
  logic [NUM_DOORS-1:0] fault_set;
  logic                 target_hit;

  assign elig_up = bus.Req_Up & bus.Dn_Max & ~bus.Up_Max & ~fault_q;
  assign elig_dn = bus.Req_Dn & bus.Up_Max & ~bus.Dn_Max & ~fault_q;
  assign elig    = elig_up | elig_dn;

  rr_arbiter #(.N(NUM_DOORS)) u_rr (
    .req (elig),
    .ptr (ptr_q),
    .gnt (gnt),
    .vld (gnt_vld)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_DOORS; i++) begin
      if (gnt[i]) gnt_idx = SEL_W'(i);
    end
  end

  assign target_hit = (state_q == MOVE_UP) ? bus.Up_Max[sel_q] : bus.Dn_Max[sel_q];

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    tmr_d     = tmr_q;
    dead_d    = dead_q;
    fault_set = '0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          sel_d   = gnt_idx;
          ptr_d   = gnt_idx;
          tmr_d   = '0;
          state_d = elig_up[gnt_idx] ? MOVE_UP : MOVE_DN;
        end
      end
      MOVE_UP, MOVE_DN: begin
        // Both end-stops at once means a broken sensor: stop before trusting either.
        if (bus.Up_Max[sel_q] && bus.Dn_Max[sel_q]) begin
          fault_set[sel_q] = 1'b1;
          state_d          = DEAD;
          dead_d           = '0;
        end else if (target_hit) begin
          state_d = DEAD;
          dead_d  = '0;
        end else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          fault_set[sel_q] = 1'b1;
          state_d          = DEAD;
          dead_d           = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      DEAD: begin
        if (dead_q == TMR_W'(DEAD_CYC - 1)) begin
          state_d = IDLE;
        end else begin
          dead_d = dead_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A fault raised in the same cycle as a clear survives.
    fault_d = (bus.Fault_Clr ? '0 : fault_q) | fault_set;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= SEL_W'(NUM_DOORS - 1);
      fault_q <= '0;
      tmr_q   <= '0;
      dead_q  <= '0;
      up_m_q  <= 1'b0;
      dn_m_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      fault_q <= fault_d;
      tmr_q   <= tmr_d;
      dead_q  <= dead_d;
      up_m_q  <= (state_d == MOVE_UP);
      dn_m_q  <= (state_d == MOVE_DN);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.Up_M  = up_m_q;
  assign bus.Dn_M  = dn_m_q;
  assign bus.Sel   = sel_q;
  assign bus.Busy  = busy_q;
  assign bus.Fault = fault_q;

endmodule

// File: tb/tb_door_motor_arbiter.sv
// Directed bench for door_motor_arbiter: dut_a uses the default timeout,
// dut_b a 20-cycle timeout for the fault scenarios.
module tb_door_motor_arbiter;
  import door_ctrl_pkg::*;

  logic CLK;
  logic RST;
  int   n_chk  = 0;
  int   n_fail = 0;

  door_motor_arbiter_if #(.NUM_DOORS(4)) ifa ();
  door_motor_arbiter_if #(.NUM_DOORS(4)) ifb ();

  door_motor_arbiter #(.NUM_DOORS(4), .TIMEOUT_CYC(1000), .DEAD_CYC(8)) dut_a (
    .CLK (CLK),
    .RST (RST),
    .bus (ifa.slave)
  );

  door_motor_arbiter #(.NUM_DOORS(4), .TIMEOUT_CYC(20), .DEAD_CYC(8)) dut_b (
    .CLK (CLK),
    .RST (RST),
    .bus (ifb.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(negedge CLK);
  endtask

  task automatic clr_inputs;
    ifa.Req_Up = '0; ifa.Req_Dn = '0; ifa.Up_Max = '0; ifa.Dn_Max = '0; ifa.Fault_Clr = 1'b0;
    ifb.Req_Up = '0; ifb.Req_Dn = '0; ifb.Up_Max = '0; ifb.Dn_Max = '0; ifb.Fault_Clr = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge CLK);
    clr_inputs();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge CLK);
    ifa.Req_Up = 4'hF; ifa.Dn_Max = 4'hF;
    ifb.Req_Up = 4'hF; ifb.Dn_Max = 4'hF;
    RST = 1'b1;
    #1;
    n_chk++;
    if ({ifa.Up_M, ifa.Dn_M, ifa.Busy, ifa.Sel, ifa.Fault} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_a: outputs=%b expected 000000000",
               {ifa.Up_M, ifa.Dn_M, ifa.Busy, ifa.Sel, ifa.Fault});
    end
    n_chk++;
    if ({ifb.Up_M, ifb.Dn_M, ifb.Busy, ifb.Sel, ifb.Fault} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_b: outputs=%b expected 000000000",
               {ifb.Up_M, ifb.Dn_M, ifb.Busy, ifb.Sel, ifb.Fault});
    end
    tick();
    tick();
    n_chk++;
    if (ifa.Busy !== 1'b0 || ifa.Up_M !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: Busy=%b Up_M=%b expected 0 0 while RST high", ifa.Busy, ifa.Up_M);
    end
    RST = 1'b0;
  endtask

  task automatic test_single_up;
    int errs;
    do_reset();
    ifa.Dn_Max = 4'hF;
    ifa.Req_Up = 4'b0100;
    tick();
    n_chk++;
    if (ifa.Sel !== 2'd2 || ifa.Up_M !== 1'b1 || ifa.Dn_M !== 1'b0 || ifa.Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: Sel=%0d Up_M=%b Dn_M=%b Busy=%b expected 2 1 0 1",
               ifa.Sel, ifa.Up_M, ifa.Dn_M, ifa.Busy);
    end
    ifa.Dn_Max[2] = 1'b0;
    errs = 0;
    for (int i = 0; i < 39; i++) begin
      tick();
      if (ifa.Up_M !== 1'b1) errs++;
    end
    n_chk++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL single_hold: Up_M dropped in %0d of 39 cycles, expected 0", errs);
    end
    ifa.Up_Max[2] = 1'b1;
    tick();
    n_chk++;
    if (ifa.Up_M !== 1'b0 || ifa.Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_stop: Up_M=%b Busy=%b expected 0 1", ifa.Up_M, ifa.Busy);
    end
    errs = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (ifa.Busy !== 1'b1 || ifa.Up_M !== 1'b0 || ifa.Dn_M !== 1'b0) errs++;
    end
    n_chk++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL single_dead: %0d bad dead cycles, expected 0", errs);
    end
    tick();
    n_chk++;
    if (ifa.Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: Busy=%b expected 0", ifa.Busy);
    end
  endtask

  task automatic test_round_robin;
    int w;
    int cnt;
    do_reset();
    ifa.Dn_Max = 4'hF;
    ifa.Req_Up = 4'hF;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (ifa.Up_M !== 1'b1 && w < 50) begin
        tick();
        w++;
      end
      n_chk++;
      if (ifa.Up_M !== 1'b1 || ifa.Sel !== k[1:0]) begin
        n_fail++;
        $display("FAIL rr_grant: Up_M=%b Sel=%0d expected 1 %0d", ifa.Up_M, ifa.Sel, k);
      end
      ifa.Dn_Max[k] = 1'b0;
      tick();
      tick();
      ifa.Up_Max[k] = 1'b1;
      tick();
      cnt = 0;
      while (ifa.Busy === 1'b1 && ifa.Up_M === 1'b0 && cnt < 20) begin
        cnt++;
        tick();
      end
      n_chk++;
      if (cnt != 8) begin
        n_fail++;
        $display("FAIL rr_dead: door %0d dead cycles=%0d expected 8", k, cnt);
      end
    end
  endtask

  task automatic test_timeout;
    int errs;
    do_reset();
    ifb.Dn_Max = 4'b0010;
    ifb.Req_Up = 4'b0010;
    tick();
    n_chk++;
    if (ifb.Up_M !== 1'b1 || ifb.Sel !== 2'd1) begin
      n_fail++;
      $display("FAIL tmo_grant: Up_M=%b Sel=%0d expected 1 1", ifb.Up_M, ifb.Sel);
    end
    errs = 0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (ifb.Up_M !== 1'b1 || ifb.Fault !== 4'b0000) errs++;
    end
    n_chk++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL tmo_early: %0d early stop/fault cycles, expected 0", errs);
    end
    tick();
    n_chk++;
    if (ifb.Fault !== 4'b0010 || ifb.Up_M !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_fault: Fault=%b Up_M=%b expected 0010 0", ifb.Fault, ifb.Up_M);
    end
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ifb.Up_M !== 1'b0 || ifb.Dn_M !== 1'b0) errs++;
    end
    n_chk++;
    if (errs != 0 || ifb.Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_locked: %0d motor cycles, Busy=%b expected 0 0", errs, ifb.Busy);
    end
    ifb.Fault_Clr = 1'b1;
    tick();
    ifb.Fault_Clr = 1'b0;
    n_chk++;
    if (ifb.Fault !== 4'b0000 || ifb.Up_M !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_clear: Fault=%b Up_M=%b expected 0000 0", ifb.Fault, ifb.Up_M);
    end
    tick();
    n_chk++;
    if (ifb.Up_M !== 1'b1 || ifb.Sel !== 2'd1) begin
      n_fail++;
      $display("FAIL tmo_regrant: Up_M=%b Sel=%0d expected 1 1", ifb.Up_M, ifb.Sel);
    end
    for (int i = 0; i < 19; i++) tick();
    ifb.Fault_Clr = 1'b1;
    tick();
    ifb.Fault_Clr = 1'b0;
    n_chk++;
    if (ifb.Fault !== 4'b0010 || ifb.Up_M !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_set_wins: Fault=%b Up_M=%b expected 0010 0", ifb.Fault, ifb.Up_M);
    end
  endtask

  task automatic test_both_sensors;
    do_reset();
    ifa.Up_Max = 4'b0001;
    ifa.Req_Dn = 4'b0001;
    tick();
    n_chk++;
    if (ifa.Dn_M !== 1'b1 || ifa.Up_M !== 1'b0 || ifa.Sel !== 2'd0) begin
      n_fail++;
      $display("FAIL conflict_grant: Dn_M=%b Up_M=%b Sel=%0d expected 1 0 0",
               ifa.Dn_M, ifa.Up_M, ifa.Sel);
    end
    ifa.Dn_Max[0] = 1'b1;
    tick();
    n_chk++;
    if (ifa.Fault !== 4'b0001 || ifa.Dn_M !== 1'b0 || ifa.Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL conflict_fault: Fault=%b Dn_M=%b Busy=%b expected 0001 0 1",
               ifa.Fault, ifa.Dn_M, ifa.Busy);
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    ifa.Dn_Max = 4'hF;
    ifa.Req_Up = 4'b0010;
    tick();
    n_chk++;
    if (ifa.Up_M !== 1'b1 || ifa.Sel !== 2'd1) begin
      n_fail++;
      $display("FAIL arst_grant: Up_M=%b Sel=%0d expected 1 1", ifa.Up_M, ifa.Sel);
    end
    ifa.Req_Up = 4'b0000;
    tick();
    #2;
    RST = 1'b1;
    #1;
    n_chk++;
    if (ifa.Up_M !== 1'b0 || ifa.Busy !== 1'b0 || ifa.Sel !== 2'd0) begin
      n_fail++;
      $display("FAIL arst_drop: Up_M=%b Busy=%b Sel=%0d expected 0 0 0", ifa.Up_M, ifa.Busy, ifa.Sel);
    end
    #1;
    RST = 1'b0;
    ifa.Req_Up = 4'b0101;
    tick();
    n_chk++;
    if (ifa.Up_M !== 1'b1 || ifa.Sel !== 2'd0) begin
      n_fail++;
      $display("FAIL arst_first: Up_M=%b Sel=%0d expected 1 0", ifa.Up_M, ifa.Sel);
    end
  endtask

  task automatic test_invalid_status;
    int errs;
    do_reset();
    ifa.Req_Up = 4'hF;
    ifa.Req_Dn = 4'hF;
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ifa.Busy !== 1'b0 || ifa.Up_M !== 1'b0 || ifa.Dn_M !== 1'b0) errs++;
    end
    n_chk++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL invalid_status: %0d busy/motor cycles, expected 0", errs);
    end
  endtask

  initial begin
    RST = 1'b1;
    clr_inputs();
    test_reset();
    test_single_up();
    test_round_robin();
    test_timeout();
    test_both_sensors();
    test_async_reset();
    test_invalid_status();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
